// File: rtl/mem_xfer_unit_pkg.sv
// Shared types and width helpers for the memory transfer unit.
package mem_xfer_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    FAULT  = 2'd3
  } xfer_state_t;

  // Number of address bits that select a byte lane within one data word.
  function automatic int laneBits(input int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

  // Counter width able to hold the value maxWait itself.
  function automatic int cntBits(input int maxWait);
    return $clog2(maxWait + 1);
  endfunction

endpackage

// File: rtl/mem_xfer_unit_lane_align.sv
// Byte-lane steering between the MDR and the memory data bus.
module lane_align
  import mem_xfer_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  localparam int LANE_BITS = laneBits(DATA_WIDTH),
  localparam int BYTES     = DATA_WIDTH / 8
) (
  input  logic [LANE_BITS-1:0]  lane,
  input  logic                  isByte,
  input  logic [DATA_WIDTH-1:0] mdr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [BYTES-1:0]      byteEn,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdataAligned
);

  // Word accesses pass straight through; byte accesses replicate the write
  // byte onto every lane and pull the addressed read lane down to bit 0.
  always_comb begin
    byteEn       = '1;
    wdata        = mdr;
    rdataAligned = rdata;
    if (isByte) begin
      byteEn       = '0;
      wdata        = {BYTES{mdr[7:0]}};
      rdataAligned = '0;
      for (int i = 0; i < BYTES; i++) begin
        if (lane == LANE_BITS'(i)) begin
          byteEn[i]         = 1'b1;
          rdataAligned[7:0] = rdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_xfer_unit.sv
// MAR/MDR owner running one handshaked memory transaction at a time.
//
//   state  | meaning
//   -------+------------------------------------------------------
//   IDLE   | ready for a request; MDR loadable from the ALU
//   ACCESS | strobe held until mem_ack or wait budget exhausted
//   RESP   | one-cycle done pulse
//   FAULT  | one-cycle err pulse (misaligned word or timeout)
module mem_xfer_unit
  import mem_xfer_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    mdr_load,
  input  logic [DATA_WIDTH-1:0]   mdr_in,
  output logic [DATA_WIDTH-1:0]   mdr_out,
  output logic [ADDR_WIDTH-1:0]   mar_out,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  localparam int LANE_BITS = laneBits(DATA_WIDTH);
  localparam int CNT_BITS  = cntBits(MAX_WAIT);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam logic [CNT_BITS-1:0] WAIT_LAST = CNT_BITS'(MAX_WAIT - 1);

  xfer_state_t             state, nextState;
  logic [ADDR_WIDTH-1:0]   mar;
  logic [DATA_WIDTH-1:0]   mdr;
  logic                    isWrite;
  logic                    isByte;
  logic [CNT_BITS-1:0]     waitCnt;
  logic                    accept;
  logic                    misaligned;
  logic [BYTES-1:0]        laneEn;
  logic [DATA_WIDTH-1:0]   alignedWdata;
  logic [DATA_WIDTH-1:0]   alignedRdata;

  assign accept     = req_valid && (state == IDLE);
  assign misaligned = !req_byte && (req_addr[LANE_BITS-1:0] != '0);

  assign mdr_out  = mdr;
  assign mar_out  = mar;
  assign mem_addr = {mar[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};

  lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uAlign (
    .lane        (mar[LANE_BITS-1:0]),
    .isByte      (isByte),
    .mdr         (mdr),
    .rdata       (mem_rdata),
    .byteEn      (laneEn),
    .wdata       (alignedWdata),
    .rdataAligned(alignedRdata)
  );

  // State register; reset returns to IDLE so strobes drop immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and Moore outputs; ack takes priority over wait expiry.
  always_comb begin
    nextState = state;
    req_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) nextState = misaligned ? FAULT : ACCESS;
      end
      ACCESS: begin
        mem_re = !isWrite;
        mem_we = isWrite;
        mem_be = laneEn;
        if (isWrite) mem_wdata = alignedWdata;
        if (mem_ack)                   nextState = RESP;
        else if (waitCnt == WAIT_LAST) nextState = FAULT;
      end
      RESP: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      FAULT: begin
        err       = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // MAR/MDR, request attributes and the wait counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mar     <= '0;
      mdr     <= '0;
      isWrite <= 1'b0;
      isByte  <= 1'b0;
      waitCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdr_load) mdr <= mdr_in;
          if (accept) begin
            mar     <= req_addr;
            isWrite <= req_write;
            isByte  <= req_byte;
            waitCnt <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!isWrite) mdr <= alignedRdata;
          end else begin
            waitCnt <= waitCnt + CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
